// File: rtl/mac_plm_addr_gen.sv
// PLM word-index generator: emits len consecutive (or strided) 12-bit indices tagged with DMA32 beat position.
// Optional MAC_PLM_ADDR_GEN_STRIDE_EN adds a per-transfer stride input; default increment is 1.
module mac_plm_addr_gen #(
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 13,
  parameter int BEAT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_last_beat,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] step;
  logic              hs;
  logic              accept;

`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  assign hs            = out_valid && out_ready;
  assign accept        = (state == IDLE) && start && (len != '0);
  assign out_last      = out_valid && (remaining == LEN_W'(1));
  assign out_last_beat = out_valid && ((out_beat == '1) || out_last);
  assign busy          = (state == RUN);
  assign done          = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
      RUN:     if (hs && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output stage: loads on acceptance, advances only on a handshake so stalls hold everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_beat  <= '0;
      remaining <= '0;
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
      stride_q  <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_addr  <= base;
      out_beat  <= '0;
      remaining <= len;
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
      stride_q  <= stride;
`endif
    end else if ((state == RUN) && hs) begin
      out_beat <= out_beat + BEAT_W'(1);
      if (out_last) begin
        out_valid <= 1'b0;
      end else begin
        out_addr  <= out_addr + step;
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_plm_addr_gen.sv
// Scoreboard bench for mac_plm_addr_gen: stimulus pushes model beats, a negedge monitor pops on handshakes.
module tb_mac_plm_addr_gen;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 13;
  localparam int BEAT_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
  logic [ADDR_W-1:0] stride;
`endif
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [BEAT_W-1:0] out_beat;
  logic              out_last_beat;
  logic              out_last;
  logic              busy;
  logic              done;

  mac_plm_addr_gen dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .len(len),
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
    .stride(stride),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_beat(out_beat), .out_last_beat(out_last_beat), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] beat;
    logic              lb;
    logic              last;
  } beat_t;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    ready_mode = 0;
  int    rcnt = 0;
  int    pops = 0;
  int    zero_req = 0, zero_seen = 0;
  int    flush_req = 0, flush_seen = 0;
  logic  done_due = 1'b0;
  logic  prev_stall = 1'b0;
  beat_t held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Ready generator: always-on, fixed 1,0,0 pattern, or random.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       begin out_ready = (rcnt % 3 == 0); rcnt++; end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops one expected beat per handshake, checks stalls, done and busy.
  always @(negedge clk) begin
    beat_t cur, e;
    logic  exp_done;
    if (!rst) begin
      if (flush_req != flush_seen) begin
        flush_seen = flush_req;
        sb.delete();
        done_due   = 1'b0;
        prev_stall = 1'b0;
      end
      cur      = {out_addr, out_beat, out_last_beat, out_last};
      exp_done = done_due;
      done_due = 1'b0;
      if (zero_req != zero_seen) begin
        zero_seen = zero_req;
        exp_done  = 1'b1;
      end
      if (done || exp_done) chk("done", 32'(done), 32'(exp_done));
      if (busy || out_valid) chk("busy", 32'(busy), 32'(out_valid));
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(held));
      end
      prev_stall = out_valid && !out_ready;
      held       = cur;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got addr %0h, no beat expected", out_addr);
        end else begin
          e = sb.pop_front();
          pops++;
          chk("addr", 32'(out_addr), 32'(e.addr));
          chk("beat", 32'(out_beat), 32'(e.beat));
          chk("last_beat", 32'(out_last_beat), 32'(e.lb));
          chk("last", 32'(out_last), 32'(e.last));
          if (e.last) done_due = 1'b1;
        end
      end
    end
  end

  task automatic wait_idle();
    int c = 0;
    @(negedge clk);
    while ((sb.size() != 0 || busy || done) && c < 20000) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (c >= 20000) begin
      n_fail++;
      $display("FAIL timeout: %0d beats still pending", sb.size());
      flush_req++;
    end
  endtask

  // Reference: beat i has address base+i*stride mod 4096, position i mod 16.
  task automatic push_model(input logic [ADDR_W-1:0] b, input int l, input logic [ADDR_W-1:0] s);
    beat_t e;
    for (int i = 0; i < l; i++) begin
      e.addr = ADDR_W'((int'(b) + i * int'(s)) % 4096);
      e.beat = BEAT_W'(i % 16);
      e.last = (i == l - 1);
      e.lb   = (i % 16 == 15) || e.last;
      sb.push_back(e);
    end
  endtask

  task automatic drive_start(input logic [ADDR_W-1:0] b, input int l, input logic [ADDR_W-1:0] s);
    start = 1'b1;
    base  = b;
    len   = LEN_W'(l);
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
    stride = s;
`endif
  endtask

  task automatic scramble();
    start = 1'b0;
    base  = ADDR_W'($urandom);
    len   = LEN_W'($urandom);
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
    stride = ADDR_W'($urandom);
`endif
  endtask

  task automatic run_xfer(input logic [ADDR_W-1:0] b, input int l, input logic [ADDR_W-1:0] s, input bit poke);
    logic [ADDR_W-1:0] eff;
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
    eff = s;
`else
    eff = ADDR_W'(1);
`endif
    wait_idle();
    push_model(b, l, eff);
    @(posedge clk); #1;
    drive_start(b, l, s);
    @(posedge clk); #1;
    scramble();
    if (l == 0) zero_req++;
    @(negedge clk);
    chk("first_valid", 32'(out_valid), (l != 0) ? 32'd1 : 32'd0);
    if (l != 0) chk("first_addr", 32'(out_addr), 32'(b));
    if (poke) begin
      @(posedge clk); #1;
      drive_start(ADDR_W'(12'h777), 5, ADDR_W'(3));
      repeat (2) @(posedge clk);
      #1 start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    int p0;
    int c;
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
    stride = '0;
`endif
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("idle_outs", {out_valid, out_addr, out_beat, out_last_beat, out_last}, 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
    end

    ready_mode = 0;
    run_xfer(12'h010, 20, 12'd1, 1'b0);

    rcnt = 0;
    ready_mode = 1;
    p0 = pops;
    run_xfer(12'hFFE, 4, 12'd1, 1'b0);
    chk("wrap_handshakes", 32'(pops - p0), 32'd4);

    ready_mode = 0;
    run_xfer(12'h123, 0, 12'd1, 1'b0);
    p0 = pops;
    run_xfer(12'h200, 8, 12'd1, 1'b1);
    chk("poke_handshakes", 32'(pops - p0), 32'd8);

    // Start held across DONE is ignored there and accepted in the following IDLE cycle.
    wait_idle();
    push_model(12'h300, 3, 12'd1);
    @(posedge clk); #1;
    drive_start(12'h300, 3, 12'd1);
    @(posedge clk); #1;
    scramble();
    c = 0;
    while (!done && c < 100) begin @(negedge clk); c++; end
    chk("b2b_done_seen", 32'(done), 32'd1);
    push_model(12'h400, 2, 12'd1);
    drive_start(12'h400, 2, 12'd1);
    @(posedge clk); #1;
    chk("start_ignored_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    scramble();
    @(negedge clk);
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_addr", 32'(out_addr), 32'h400);
    wait_idle();

    // Asynchronous abort mid-transfer.
    push_model(12'h500, 32, 12'd1);
    @(posedge clk); #1;
    drive_start(12'h500, 32, 12'd1);
    @(posedge clk); #1;
    scramble();
    c = 0;
    @(negedge clk);
    while (out_beat != 4'd5 && c < 200) begin @(negedge clk); c++; end
    chk("reached_beat5", 32'(out_beat), 32'd5);
    #2 rst = 1'b1;
    #1;
    chk("abort_outs", {out_valid, out_addr, out_beat, out_last_beat, out_last}, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    #1 rst = 1'b0;
    flush_req++;
    repeat (4) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    p0 = pops;
    run_xfer(12'h500, 32, 12'd1, 1'b0);
    chk("fresh_handshakes", 32'(pops - p0), 32'd32);

`ifdef MAC_PLM_ADDR_GEN_STRIDE_EN
    run_xfer(12'h100, 3, 12'd4, 1'b0);
    run_xfer(12'h0AB, 5, 12'd0, 1'b0);
    run_xfer(12'hFF0, 7, 12'hF05, 1'b0);
`endif

    ready_mode = 0;
    run_xfer(12'hABC, 4096, 12'd1, 1'b0);

    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      run_xfer(ADDR_W'($urandom), int'($urandom_range(0, 40)), ADDR_W'($urandom_range(0, 9)), 1'b0);
    end

    wait_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
